// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state encoding and iteration count.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Default datapath width; one iteration per operand bit.
    localparam int ITER = 32;

    // Op field encodings. Op[1] selects divide, Op[0] selects signed.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_if
// Description : Pipeline-side bundle of the multiply/divide unit.
//               master : pipeline control / register file (drives requests)
//               slave  : mult_div_unit (returns status and HI/LO)
//   Start      launch operation selected by Op (IDLE only)
//   Op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   SrcA/SrcB  operands (RD1/RD2); SrcA also carries MTHI/MTLO data
//   MtHi/MtLo  move SrcA into HI/LO
//   Busy       operation in progress
//   Done       one-cycle pulse when HI/LO take a new result
//   DivByZero  qualifies Done for a divide with a zero divisor
//   Hi/Lo      architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             MtHi;
    logic             MtLo;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, SrcA, SrcB, MtHi, MtLo,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, SrcA, SrcB, MtHi, MtLo,
        output Busy, Done, DivByZero, Hi, Lo
    );

endinterface : mult_div_unit_if
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative multiply/divide unit with architectural HI/LO.
//               Shift-add multiply and restoring divide on magnitudes, one bit
//               per cycle for WIDTH cycles, followed by a sign-fix/commit
//               cycle. Signed operations are corrected in the FIX state.
// Ports       :
//   CLK   rising-edge clock
//   RST   asynchronous active-high reset
//   bus   mult_div_unit_if slave modport (Start/Op/SrcA/SrcB/MtHi/MtLo in,
//         Busy/Done/DivByZero/Hi/Lo out)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    mult_div_unit_if.slave    bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   C_ONE_W    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] C_ONE_2W   = (2*WIDTH)'(1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + C_ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + C_ONE_2W;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dbz;       // divide-by-zero detected at Start
    logic [WIDTH-1:0]   r_src_a;     // raw SrcA, committed to HI on divide by zero
    logic [WIDTH-1:0]   r_opnd;      // multiplicand (mult) or divisor (div)
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide  : low half is the dividend shifting out / quotient shifting in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;       // restored partial remainder
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divz;

    // ------------------------------------------------------------------
    // FSM control
    // ------------------------------------------------------------------
    state_t w_state_nxt;
    logic   w_start_ok;
    logic   w_move_ok;
    logic   w_iter;
    logic   w_commit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_move_ok   = 1'b0;
        w_iter      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                // Start has priority: a simultaneous move is dropped.
                if (bus.Start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = RUN;
                end else if (bus.MtHi || bus.MtLo) begin
                    w_move_ok = 1'b1;
                end
            end
            RUN: begin
                w_iter = 1'b1;
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    logic             w_neg_a_in;
    logic             w_neg_b_in;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_neg_a_in = bus.Op[0] & bus.SrcA[WIDTH-1];
    assign w_neg_b_in = bus.Op[0] & bus.SrcB[WIDTH-1];
    assign w_abs_a    = w_neg_a_in ? neg_w(bus.SrcA) : bus.SrcA;
    assign w_abs_b    = w_neg_b_in ? neg_w(bus.SrcB) : bus.SrcB;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;

    // Add the multiplicand into the upper half when the current multiplier
    // bit is set, then shift the whole accumulator right with the carry.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit, try the subtraction,
    // keep it only when it does not go negative.
    assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};

    always_comb begin
        w_div_rem = w_div_shift[WIDTH-1:0];
        w_div_quo = {r_acc[WIDTH-2:0], 1'b0};
        if (!w_div_trial[WIDTH]) begin
            w_div_rem = w_div_trial[WIDTH-1:0];
            w_div_quo = {r_acc[WIDTH-2:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix and commit values
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    always_comb begin
        w_prod = r_acc;
        w_quo  = r_acc[WIDTH-1:0];
        w_rem  = r_rem;
        if (r_op == OP_MULT && (r_sign_a ^ r_sign_b)) begin
            w_prod = neg_2w(r_acc);
        end
        if (r_op == OP_DIV && (r_sign_a ^ r_sign_b)) begin
            w_quo = neg_w(r_acc[WIDTH-1:0]);
        end
        // Remainder follows the sign of the dividend.
        if (r_op == OP_DIV && r_sign_a) begin
            w_rem = neg_w(r_rem);
        end

        if (r_op[1]) begin
            if (r_dbz) begin
                w_res_hi = r_src_a;
                w_res_lo = {WIDTH{1'b1}};
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_op     <= OP_MULTU;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dbz    <= 1'b0;
            r_src_a  <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_divz   <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_divz <= w_commit & r_dbz;

            if (w_start_ok) begin
                r_cnt    <= '0;
                r_op     <= bus.Op;
                r_sign_a <= w_neg_a_in;
                r_sign_b <= w_neg_b_in;
                r_dbz    <= bus.Op[1] & (bus.SrcB == '0);
                r_src_a  <= bus.SrcA;
                r_rem    <= '0;
                if (bus.Op[1]) begin
                    r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                    r_opnd <= w_abs_b;
                end else begin
                    r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                    r_opnd <= w_abs_a;
                end
            end

            if (w_iter) begin
                r_cnt <= r_cnt + C_CNT_ONE;
                if (r_op[1]) begin
                    r_rem             <= w_div_rem;
                    r_acc[WIDTH-1:0]  <= w_div_quo;
                end else begin
                    r_acc <= w_mul_acc;
                end
            end

            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end

            if (w_move_ok) begin
                if (bus.MtHi) begin
                    r_hi <= bus.SrcA;
                end
                if (bus.MtLo) begin
                    r_lo <= bus.SrcA;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.Busy      = (r_state != IDLE);
    assign bus.Done      = r_done;
    assign bus.DivByZero = r_divz;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Expected HI/LO/flag
//               values come from a behavioural model and are queued when an
//               operation is launched, then popped when Done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (op)
            OP_MULTU: begin
                p    = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULT: begin
                p    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    e.dbz = 1'b1;
                    e.hi  = a;
                    e.lo  = '1;
                end else if (op == OP_DIVU) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = '0;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
        endcase
        return e;
    endfunction

    // Drive Start at the current (negedge) time for one cycle.
    task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit push);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        if (push) sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.Start = 1'b0;
        bus.MtHi  = 1'b0;
        bus.MtLo  = 1'b0;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        @(negedge clk);
        drive_start(op, a, b, 1'b1);
    endtask

    // Returns at the negedge where Done is high; exp_busy is the number of
    // Busy samples still expected from the call point.
    task automatic wait_done(input string tag, input int exp_busy);
        int   busy_cnt = 0;
        int   cyc      = 0;
        bit   seen     = 0;
        exp_t e;
        while (!seen && cyc < 100) begin
            if (bus.Done) begin
                seen = 1;
            end else begin
                if (bus.Busy) busy_cnt++;
                cyc++;
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(exp_busy));
            chk({tag, "_busy_low_at_done"}, 64'(bus.Busy), 64'd0);
            chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_hi"},  64'(bus.Hi),        64'(e.hi));
                chk({tag, "_lo"},  64'(bus.Lo),        64'(e.lo));
                chk({tag, "_dbz"}, 64'(bus.DivByZero), 64'(e.dbz));
            end
        end
    endtask

    task automatic post_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_drop"}, 64'(bus.Done),      64'd0);
        chk({tag, "_dbz_drop"},  64'(bus.DivByZero), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(op, a, b);
        wait_done(tag, 33);
        post_done(tag);
    endtask

    initial begin
        logic [W-1:0] prev_lo;
        int           dn;
        bus.Start = 1'b0;
        bus.Op    = OP_MULTU;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        bus.MtHi  = 1'b0;
        bus.MtLo  = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_dbz",  64'(bus.DivByZero), 64'd0);
        chk("rst_hi",   64'(bus.Hi), 64'd0);
        chk("rst_lo",   64'(bus.Lo), 64'd0);
        rst = 1'b0;

        // Directed arithmetic cases
        run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'd5);
        run_op("mult_min",   OP_MULT,  32'h8000_0000, 32'h8000_0000);
        run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", OP_DIVU,  32'd100,       32'd7);
        run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_zero",  OP_DIVU,  32'h0000_1234, 32'd0);
        run_op("div_zero",   OP_DIV,   32'hFFFF_FF00, 32'd0);
        run_op("div_negrem", OP_DIV,   32'd7,         32'hFFFF_FFFE);

        // Random mix
        for (int i = 0; i < 12; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 7) b = '0;
            run_op($sformatf("rand%0d", i), op, a, b);
        end

        // Back-to-back: Start in the Done cycle is accepted
        start_op(OP_MULTU, 32'd1000, 32'd1000);
        wait_done("b2b_first", 33);
        drive_start(OP_DIVU, 32'd1000, 32'd10, 1'b1);
        wait_done("b2b_second", 33);
        post_done("b2b_second");

        // Start while busy is ignored
        start_op(OP_MULTU, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        drive_start(OP_DIV, 32'd100, 32'd3, 1'b0);
        wait_done("busy_start", 28);
        post_done("busy_start");

        // Reset mid-operation: no partial write, no Done
        @(negedge clk);
        drive_start(OP_MULTU, 32'h1234, 32'd5, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.Busy), 64'd0);
        chk("abort_hi",   64'(bus.Hi),   64'd0);
        chk("abort_lo",   64'(bus.Lo),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'd0);

        // MtHi / MtLo in IDLE
        bus.MtHi = 1'b1;
        bus.SrcA = 32'hCAFE_BABE;
        @(negedge clk);
        bus.MtHi = 1'b0;
        chk("mthi_hi", 64'(bus.Hi), 64'h0000_0000_CAFE_BABE);
        chk("mthi_lo", 64'(bus.Lo), 64'd0);
        bus.MtHi = 1'b1;
        bus.MtLo = 1'b1;
        bus.SrcA = 32'h0BAD_F00D;
        @(negedge clk);
        bus.MtHi = 1'b0;
        bus.MtLo = 1'b0;
        chk("mtboth_hi", 64'(bus.Hi), 64'h0000_0000_0BAD_F00D);
        chk("mtboth_lo", 64'(bus.Lo), 64'h0000_0000_0BAD_F00D);

        // MtLo while busy is ignored
        prev_lo = bus.Lo;
        start_op(OP_MULTU, 32'd3, 32'd3);
        bus.MtLo = 1'b1;
        bus.SrcA = 32'h5555_5555;
        @(negedge clk);
        bus.MtLo = 1'b0;
        chk("mtlo_busy_lo", 64'(bus.Lo), 64'(prev_lo));
        wait_done("mtlo_busy", 32);
        post_done("mtlo_busy");

        // Start and MtLo together: only the operation runs
        prev_lo = bus.Lo;
        @(negedge clk);
        bus.MtLo = 1'b1;
        drive_start(OP_MULTU, 32'h0000_AAAA, 32'd2, 1'b1);
        chk("start_mtlo_lo", 64'(bus.Lo), 64'(prev_lo));
        wait_done("start_mtlo", 33);
        post_done("start_mtlo");

        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire
